muldiv_sequencer: RTL and testbench

Sequences the multicycle Mult and Div units and the HI/LO register pair on behalf of the main control FSM. The control FSM issues a one-cycle request; the block holds the selected unit's start line, waits for its done flag, and writes HI/LO through the HI/LO source muxes. It reports divide-by-zero and watchdog timeout as exception pulses, and it stalls MFHI/MFLO reads while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 58 +++++
 rtl/muldiv_watchdog.sv | 32 +++
 rtl/muldiv_sequencer.sv | 123 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide sequencer: FSM states, operation and
// exception-cause encodings, the default watchdog limit and the output decode.
// No ports; imported by muldiv_watchdog and muldiv_sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT_RUN,
        ST_DIV_RUN,
        ST_WB,
        ST_EXC
    } state_t;

    // The op encoding doubles as the HI/LO source mux select (0 = Div, 1 = Mult).
    typedef enum logic {
        OP_DIV  = 1'b0,
        OP_MULT = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_DIV0,
        CAUSE_TIMEOUT
    } cause_t;

    localparam int TIMEOUT_DEFAULT = 40;

    typedef struct packed {
        logic mult_start;
        logic div_start;
        logic hi_sel;
        logic lo_sel;
        logic write_hi;
        logic write_lo;
        logic busy;
        logic done;
        logic div0_exc;
        logic timeout_exc;
    } outs_t;

    // Moore decode: outputs depend only on state, op and cause.
    function automatic outs_t decode(input state_t s, input op_t o, input cause_t c);
        outs_t r;
        r             = '0;
        r.mult_start  = (s == ST_MULT_RUN);
        r.div_start   = (s == ST_DIV_RUN);
        r.hi_sel      = (o == OP_MULT);
        r.lo_sel      = (o == OP_MULT);
        r.write_hi    = (s == ST_WB);
        r.write_lo    = (s == ST_WB);
        r.busy        = (s != ST_IDLE);
        r.done        = (s == ST_WB);
        r.div0_exc    = (s == ST_EXC) && (c == CAUSE_DIV0);
        r.timeout_exc = (s == ST_EXC) && (c == CAUSE_TIMEOUT);
        return r;
    endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// RUN-cycle counter for the sequencer watchdog; expired is high when count == TIMEOUT-1.
// Ports: clock, reset (sync, active-high), clear (wins over enable), enable, expired.
// Latency: clear/enable take effect on the next rising edge; expired is a decode of the count.
module muldiv_watchdog #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Holds at LAST instead of wrapping; the FSM always leaves RUN on that cycle anyway.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the Mult/Div units and the HI/LO write on a one-cycle request; raises
// div0/timeout exception pulses; stall = hilo_rd & busy (only comb input->output path).
// Latency: request -> RUN next cycle; done at N -> WB at N+1 -> IDLE at N+2.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic req_mult,
    input  logic req_div,
    input  logic abort,
    input  logic hilo_rd,
    input  logic mult_done,
    input  logic div_done,
    input  logic div0,
    output logic mult_start,
    output logic div_start,
    output logic hi_sel,
    output logic lo_sel,
    output logic write_hi,
    output logic write_lo,
    output logic busy,
    output logic stall,
    output logic done,
    output logic div0_exc,
    output logic timeout_exc
);

    state_t state, state_n;
    op_t    op, op_n;
    cause_t cause, cause_n;
    outs_t  outs;
    logic   wd_clear, wd_enable, wd_expired;

    muldiv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign wd_enable = (state == ST_MULT_RUN) || (state == ST_DIV_RUN);

    // Exit priority in RUN: abort, then div0 (div only), then done, then watchdog.
    always_comb begin
        state_n  = state;
        op_n     = op;
        cause_n  = cause;
        wd_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_mult) begin
                    state_n  = ST_MULT_RUN;
                    op_n     = OP_MULT;
                    cause_n  = CAUSE_NONE;
                    wd_clear = 1'b1;
                end else if (req_div) begin
                    state_n  = ST_DIV_RUN;
                    op_n     = OP_DIV;
                    cause_n  = CAUSE_NONE;
                    wd_clear = 1'b1;
                end
            end
            ST_MULT_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (mult_done) begin
                    state_n = ST_WB;
                end else if (wd_expired) begin
                    state_n = ST_EXC;
                    cause_n = CAUSE_TIMEOUT;
                end
            end
            ST_DIV_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (div0) begin
                    state_n = ST_EXC;
                    cause_n = CAUSE_DIV0;
                end else if (div_done) begin
                    state_n = ST_WB;
                end else if (wd_expired) begin
                    state_n = ST_EXC;
                    cause_n = CAUSE_TIMEOUT;
                end
            end
            ST_WB:   state_n = ST_IDLE;
            ST_EXC:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            op    <= OP_DIV;
            cause <= CAUSE_NONE;
            outs  <= '0;
        end else begin
            state <= state_n;
            op    <= op_n;
            cause <= cause_n;
            outs  <= decode(state_n, op_n, cause_n);
        end
    end

    assign mult_start  = outs.mult_start;
    assign div_start   = outs.div_start;
    assign hi_sel      = outs.hi_sel;
    assign lo_sel      = outs.lo_sel;
    assign write_hi    = outs.write_hi;
    assign write_lo    = outs.write_lo;
    assign busy        = outs.busy;
    assign done        = outs.done;
    assign div0_exc    = outs.div0_exc;
    assign timeout_exc = outs.timeout_exc;
    assign stall       = hilo_rd & outs.busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: two instances (TIMEOUT 40 and 8) share the inputs.
// Table-driven cycle vectors for short operations plus hand sequences for long MULT,
// watchdog boundary and mid-operation reset.
module tb_muldiv_sequencer;

    // Output vector bit masks: {mult_start,div_start,hi_sel,lo_sel,write_hi,write_lo,
    //                           busy,stall,done,div0_exc,timeout_exc}
    localparam logic [10:0] MS = 11'h400, DS = 11'h200, HS = 11'h100, LS = 11'h080;
    localparam logic [10:0] WH = 11'h040, WL = 11'h020, BZ = 11'h010, ST = 11'h008;
    localparam logic [10:0] DN = 11'h004, DZ = 11'h002, TO = 11'h001, NONE = 11'h000;
    localparam logic [10:0] WBM = HS | LS | WH | WL | BZ | DN;
    localparam logic [10:0] MRUN = MS | HS | LS | BZ;

    // Input vector masks: {req_mult,req_div,abort,hilo_rd,mult_done,div_done,div0}
    localparam logic [6:0] I_RM = 7'h40, I_RD = 7'h20, I_AB = 7'h10, I_HR = 7'h08;
    localparam logic [6:0] I_MD = 7'h04, I_DD = 7'h02, I_D0 = 7'h01, I_NO = 7'h00;

    localparam int BOTH = 3, A40 = 1, W8 = 2;

    logic clock, reset;
    logic req_mult, req_div, abort, hilo_rd, mult_done, div_done, div0;

    logic a_ms, a_ds, a_hs, a_ls, a_wh, a_wl, a_bz, a_st, a_dn, a_dz, a_to;
    logic w_ms, w_ds, w_hs, w_ls, w_wh, w_wl, w_bz, w_st, w_dn, w_dz, w_to;
    logic [10:0] oa, ow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0]  in;
        logic [10:0] exp;
    } vec_t;

    vec_t tab [24];

    muldiv_sequencer #(.TIMEOUT(40)) dut_a (
        .clock(clock), .reset(reset), .req_mult(req_mult), .req_div(req_div),
        .abort(abort), .hilo_rd(hilo_rd), .mult_done(mult_done), .div_done(div_done),
        .div0(div0), .mult_start(a_ms), .div_start(a_ds), .hi_sel(a_hs), .lo_sel(a_ls),
        .write_hi(a_wh), .write_lo(a_wl), .busy(a_bz), .stall(a_st), .done(a_dn),
        .div0_exc(a_dz), .timeout_exc(a_to)
    );

    muldiv_sequencer #(.TIMEOUT(8)) dut_w (
        .clock(clock), .reset(reset), .req_mult(req_mult), .req_div(req_div),
        .abort(abort), .hilo_rd(hilo_rd), .mult_done(mult_done), .div_done(div_done),
        .div0(div0), .mult_start(w_ms), .div_start(w_ds), .hi_sel(w_hs), .lo_sel(w_ls),
        .write_hi(w_wh), .write_lo(w_wl), .busy(w_bz), .stall(w_st), .done(w_dn),
        .div0_exc(w_dz), .timeout_exc(w_to)
    );

    assign oa = {a_ms, a_ds, a_hs, a_ls, a_wh, a_wl, a_bz, a_st, a_dn, a_dz, a_to};
    assign ow = {w_ms, w_ds, w_hs, w_ls, w_wh, w_wl, w_bz, w_st, w_dn, w_dz, w_to};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The control FSM must never request while an operation is in flight.
    always @(negedge clock) begin
        if (!reset) begin
            assert (!((req_mult || req_div) && (a_bz || w_bz)))
                else $error("request issued while busy");
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=running want=finished");
        $fatal(1, "time limit");
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [6:0] v);
        {req_mult, req_div, abort, hilo_rd, mult_done, div_done, div0} = v;
    endtask

    task automatic chk(input string nm, input int sel, input logic [10:0] exp);
        #1;
        if (sel[0]) begin
            total++;
            if (oa !== exp) begin
                bad++;
                $display("FAIL %s dut40 got=%h want=%h", nm, oa, exp);
            end
        end
        if (sel[1]) begin
            total++;
            if (ow !== exp) begin
                bad++;
                $display("FAIL %s dut8 got=%h want=%h", nm, ow, exp);
            end
        end
    endtask

    task automatic do_reset();
        drive(I_NO);
        reset = 1'b1;
        next();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(I_NO);
        repeat (2) next();
        chk("reset_state_held", BOTH, NONE);
        reset = 1'b0;

        // Cycle-by-cycle vectors; entry k is cycle k after reset.
        tab[0]  = '{I_NO,               NONE};
        tab[1]  = '{I_RD,               NONE};           // div request
        tab[2]  = '{I_HR,               DS | BZ | ST};   // RUN 1, stalling
        tab[3]  = '{I_HR | I_D0,        DS | BZ | ST};   // div0 on RUN 2
        tab[4]  = '{I_HR,               BZ | ST | DZ};   // EXC, no write
        tab[5]  = '{I_HR,               NONE};           // IDLE, stall drops
        tab[6]  = '{I_RD,               NONE};
        tab[7]  = '{I_D0 | I_DD,        DS | BZ};        // div0 beats div_done
        tab[8]  = '{I_NO,               BZ | DZ};
        tab[9]  = '{I_RM | I_RD,        NONE};           // both: mult wins
        tab[10] = '{I_MD,               MRUN};           // done in first RUN cycle
        tab[11] = '{I_NO,               WBM};
        tab[12] = '{I_RD,               HS | LS};        // back-to-back accept
        tab[13] = '{I_HR | I_DD,        DS | BZ | ST};
        tab[14] = '{I_HR,               WH | WL | BZ | DN | ST};
        tab[15] = '{I_HR,               NONE};
        tab[16] = '{I_RM,               NONE};
        tab[17] = '{I_NO,               MRUN};
        tab[18] = '{I_NO,               MRUN};
        tab[19] = '{I_NO,               MRUN};
        tab[20] = '{I_NO,               MRUN};
        tab[21] = '{I_AB | I_MD,        MRUN};           // abort beats mult_done
        tab[22] = '{I_NO,               HS | LS};        // no write, no done
        tab[23] = '{I_NO,               HS | LS};

        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(tab[i].in);
            chk($sformatf("vec%0d", i), BOTH, tab[i].exp);
            next();
        end
        drive(I_NO);

        // Long MULT on the TIMEOUT=40 instance: done at cycle 33.
        do_reset();
        drive(I_RM);
        next();
        drive(I_NO);
        for (int c = 1; c <= 33; c++) begin
            if (c == 33) drive(I_MD);
            chk($sformatf("mult_run_c%0d", c), A40, MRUN);
            next();
            drive(I_NO);
        end
        chk("mult_wb_c34", A40, WBM);
        next();
        chk("mult_idle_c35", A40, HS | LS);
        next();

        // Watchdog, TIMEOUT=8: no done -> timeout pulse at cycle 9.
        do_reset();
        drive(I_RD);
        next();
        drive(I_NO);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("wd_run_c%0d", c), W8, DS | BZ);
            next();
        end
        chk("wd_timeout_c9", W8, BZ | TO);
        next();
        chk("wd_idle_c10", W8, NONE);
        next();

        // Watchdog, div_done in the 8th RUN cycle wins over the timeout.
        do_reset();
        drive(I_RD);
        next();
        drive(I_NO);
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) drive(I_DD);
            chk($sformatf("wd2_run_c%0d", c), W8, DS | BZ);
            next();
            drive(I_NO);
        end
        chk("wd2_wb_c9", W8, WH | WL | BZ | DN);
        next();
        chk("wd2_idle_c10", W8, NONE);
        next();

        // Reset in the middle of DIV_RUN with hilo_rd held.
        do_reset();
        drive(I_RD | I_HR);
        next();
        drive(I_HR);
        chk("rst_div_run1", BOTH, DS | BZ | ST);
        next();
        chk("rst_div_run2", BOTH, DS | BZ | ST);
        reset = 1'b1;
        next();
        reset = 1'b0;
        chk("rst_div_after", BOTH, NONE);
        next();
        drive(I_NO);

        // Reset in the middle of MULT_RUN also returns the mux selects to Div.
        do_reset();
        drive(I_RM);
        next();
        drive(I_NO);
        chk("rst_mult_run1", BOTH, MRUN);
        reset = 1'b1;
        next();
        reset = 1'b0;
        chk("rst_mult_after", BOTH, NONE);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
